// File: rtl/slc3_mem_responder.sv
// Memory-side responder for the SLC-3 memory port: fixed-latency on-chip RAM
// plus one memory-mapped I/O word (switches on read, hex register on write).
module slc3_mem_responder #(
  parameter int          ADDR_BITS    = 10,
  parameter int          READ_LATENCY = 3,
  parameter logic [15:0] IO_ADDR      = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_mem_ena,
  input  logic        mem_wr_ena,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_ready,
  input  logic [15:0] sw_i,
  output logic [15:0] hex_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state, state_nxt;
  logic [3:0]             cnt;
  logic [15:0]            req_addr, req_wdata;
  logic                   req_wr;
  logic                   req_io, do_access;
  logic [ADDR_BITS-1:0]   idx;
  logic [15:0]            ram [2**ADDR_BITS];

  // High address bits are dropped for RAM (aliasing), but IO_ADDR is matched in full.
  assign idx    = req_addr[ADDR_BITS-1:0];
  assign req_io = (req_addr == IO_ADDR);

  always_comb begin
    state_nxt = state;
    do_access = 1'b0;
    case (state)
      IDLE: if (mem_mem_ena) state_nxt = BUSY;
      BUSY: begin
        if (!mem_mem_ena) state_nxt = IDLE;
        else if (cnt == 4'd0) begin
          do_access = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      mem_rdata <= 16'h0000;
      hex_o     <= 16'h0000;
      req_addr  <= 16'h0000;
      req_wdata <= 16'h0000;
      req_wr    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && mem_mem_ena) begin
        req_addr  <= mem_addr;
        req_wdata <= mem_wdata;
        req_wr    <= mem_wr_ena;
        cnt       <= 4'(READ_LATENCY - 1);
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (do_access) begin
        if (req_wr) begin
          mem_rdata <= req_wdata;
          if (req_io) hex_o <= req_wdata;
        end else if (req_io) begin
          mem_rdata <= sw_i;
        end else begin
          mem_rdata <= ram[idx];
        end
      end
    end
  end

  // RAM has no reset; a write pending when reset hits is dropped.
  always_ff @(posedge clk) begin
    if (!reset && do_access && req_wr && !req_io) ram[idx] <= req_wdata;
  end

  assign busy_o    = (state == BUSY);
  assign mem_ready = (state == DONE);

endmodule
